// File: rtl/mem_1024x8_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_fifo_pkg : shared constants and types for the 1024x8 tile FIFO controller
// Rev 1.0
// ============================================================================
package mem_fifo_pkg;

    localparam int MEM_AW    = 10;
    localparam int MEM_DW    = 8;
    localparam int MEM_DEPTH = 1024;
    localparam int FIFO_CAP  = MEM_DEPTH + 2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    typedef logic [MEM_AW:0] ptr_t;
    typedef logic [MEM_AW:0] count_t;

endpackage
`default_nettype wire

// File: rtl/mem_1024x8_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_fifo_stream_if / mem_tile_if : push/pop stream and memory-tile buses
// Rev 1.0
// ============================================================================
interface mem_fifo_stream_if;
    import mem_fifo_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [MEM_DW-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [MEM_DW-1:0] rd_data;

    modport master (output wr_valid, wr_data, rd_ready,
                    input  wr_ready, rd_valid, rd_data);
    modport slave  (input  wr_valid, wr_data, rd_ready,
                    output wr_ready, rd_valid, rd_data);
endinterface

interface mem_tile_if;
    import mem_fifo_pkg::*;

    // Tile buses are MSB-at-index-0
    logic [0:MEM_AW-1] mem_waddr;
    logic [0:MEM_AW-1] mem_raddr;
    logic [0:MEM_DW-1] mem_data_in;
    logic [0:MEM_DW-1] mem_data_out;
    logic              mem_wen;
    logic              mem_ren;

    modport master (output mem_waddr, mem_raddr, mem_data_in, mem_wen, mem_ren,
                    input  mem_data_out);
    modport slave  (input  mem_waddr, mem_raddr, mem_data_in, mem_wen, mem_ren,
                    output mem_data_out);
endinterface
`default_nettype wire

// File: rtl/mem_1024x8_fifo_ctrl_obuf.sv
`default_nettype none
// ============================================================================
// mem_fifo_obuf : 2-entry registered first-word-fall-through output buffer
// Rev 1.0
// ============================================================================
module mem_fifo_obuf #(
    parameter int DW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush,
    input  wire logic          push,
    input  wire logic [DW-1:0] push_data,
    input  wire logic          pop,
    output logic [1:0]         cnt,
    output logic [1:0]         cnt_next,
    output logic [DW-1:0]      head
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_cnt;

    always_comb begin
        cnt_next = r_cnt;
        if (flush) begin
            cnt_next = 2'd0;
        end else begin
            cnt_next = r_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            r_cnt <= cnt_next;
            if (!flush) begin
                case ({push, pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) r_head <= push_data;
                        else               r_tail <= push_data;
                    end
                    2'b01: r_head <= r_tail;
                    2'b11: begin
                        // Simultaneous pop and capture: new data lands behind any survivor
                        if (r_cnt == 2'd1) begin
                            r_head <= push_data;
                        end else begin
                            r_head <= r_tail;
                            r_tail <= push_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cnt  = r_cnt;
    assign head = r_head;

endmodule
`default_nettype wire

// File: rtl/mem_1024x8_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// mem_1024x8_fifo_ctrl : streaming FIFO controller for the 1024x8 memory tile
// Rev 1.0
// ============================================================================
module mem_1024x8_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int DEPTH     = MEM_DEPTH,
    parameter int AF_THRESH = 1020
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    mem_fifo_stream_if.slave  stream,
    mem_tile_if.master        tile,
    output count_t            count,
    output logic              almost_full
);

    localparam ptr_t   c_depth = ptr_t'(DEPTH);
    localparam count_t c_af    = count_t'(AF_THRESH);

    ptr_t          r_wptr;
    ptr_t          r_rptr;
    logic          r_inflight;
    logic          r_alive;
    logic [AW-1:0] r_raddr;

    ptr_t          w_mem_cnt;
    ptr_t          w_wptr_next;
    ptr_t          w_rptr_next;
    count_t        w_count_next;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_ren;
    logic [2:0]    w_occ;
    logic [1:0]    w_obuf_cnt;
    logic [1:0]    w_obuf_cnt_next;
    logic [DW-1:0] w_head;

    always_comb begin
        w_mem_cnt    = r_wptr - r_rptr;
        w_full       = (w_mem_cnt == c_depth);
        w_push       = stream.wr_valid && r_alive && !w_full && !flush;
        w_pop        = (w_obuf_cnt != 2'd0) && stream.rd_ready;
        // Output-side occupancy after this cycle's pop; a new read must not overrun the buffer
        w_occ        = {1'b0, w_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_ren        = (w_mem_cnt != '0) && !flush && (w_occ < 3'd2);
        w_wptr_next  = flush ? '0 : r_wptr + ptr_t'(w_push);
        w_rptr_next  = flush ? '0 : r_rptr + ptr_t'(w_ren);
        w_count_next = count_t'(w_wptr_next - w_rptr_next) + count_t'(w_ren)
                     + count_t'(w_obuf_cnt_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_inflight  <= 1'b0;
            r_alive     <= 1'b0;
            r_raddr     <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_wptr      <= w_wptr_next;
            r_rptr      <= w_rptr_next;
            r_inflight  <= w_ren;
            if (w_ren) begin
                r_raddr <= r_rptr[AW-1:0];
            end
            count       <= w_count_next;
            almost_full <= (w_count_next >= c_af);
        end
    end

    mem_fifo_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (r_inflight),
        .push_data (tile.mem_data_out),
        .pop       (w_pop),
        .cnt       (w_obuf_cnt),
        .cnt_next  (w_obuf_cnt_next),
        .head      (w_head)
    );

    assign stream.wr_ready = r_alive && !w_full && !flush;
    assign stream.rd_valid = (w_obuf_cnt != 2'd0);
    assign stream.rd_data  = w_head;

    assign tile.mem_wen     = w_push;
    assign tile.mem_waddr   = r_wptr[AW-1:0];
    assign tile.mem_data_in = stream.wr_data;
    assign tile.mem_ren     = w_ren;
    assign tile.mem_raddr   = w_ren ? r_rptr[AW-1:0] : r_raddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_1024x8_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_1024x8_fifo_ctrl : scoreboard bench with a registered-read tile model
// Rev 1.0
// ============================================================================
module tb_mem_1024x8_fifo_ctrl;
    import mem_fifo_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    count_t count;
    logic   almost_full;

    mem_fifo_stream_if stream_if();
    mem_tile_if        tile_if();

    mem_1024x8_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .stream      (stream_if),
        .tile        (tile_if),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_arr [0:1023];
    logic [7:0] dout_r;
    always @(posedge clk) begin
        if (tile_if.mem_wen) mem_arr[tile_if.mem_waddr] <= tile_if.mem_data_in;
        if (tile_if.mem_ren) dout_r <= mem_arr[tile_if.mem_raddr];
    end
    assign tile_if.mem_data_out = dout_r;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_total = 0;
    int ren_total = 0;

    logic [7:0]  exp_q[$];
    logic [10:0] wa_m, ra_m, m_memc;
    int          obuf_m, m_occ;
    bit          infl_m, alive_m, m_push, m_pop, m_ren, m_exp_ren, m_exp_rdy;
    logic [7:0]  m_exp_data;

    // Cycle-level reference model; sampled mid-cycle, updated for the coming edge
    initial begin : monitor
        wa_m = '0; ra_m = '0; obuf_m = 0; infl_m = 0; alive_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                wa_m = '0; ra_m = '0; obuf_m = 0; infl_m = 0; alive_m = 0;
            end else begin
                m_memc    = wa_m - ra_m;
                m_push    = stream_if.wr_valid && stream_if.wr_ready;
                m_pop     = stream_if.rd_valid && stream_if.rd_ready;
                m_ren     = tile_if.mem_ren;
                m_occ     = obuf_m + int'(infl_m) - int'(m_pop);
                m_exp_ren = (m_memc != 0) && !flush && (m_occ < 2);
                m_exp_rdy = alive_m && !flush && (m_memc != 11'd1024);

                n_checks++;
                if (count !== count_t'(exp_q.size())) begin
                    n_fail++; $display("FAIL count: got %0d expected %0d", count, exp_q.size());
                end
                n_checks++;
                if (almost_full !== (exp_q.size() >= 1020)) begin
                    n_fail++; $display("FAIL almost_full: got %b at occupancy %0d", almost_full, exp_q.size());
                end
                n_checks++;
                if (stream_if.wr_ready !== m_exp_rdy) begin
                    n_fail++; $display("FAIL wr_ready: got %b expected %b", stream_if.wr_ready, m_exp_rdy);
                end
                n_checks++;
                if (tile_if.mem_wen !== m_push) begin
                    n_fail++; $display("FAIL mem_wen: got %b expected %b", tile_if.mem_wen, m_push);
                end
                n_checks++;
                if (stream_if.rd_valid !== (obuf_m != 0)) begin
                    n_fail++; $display("FAIL rd_valid: got %b expected %b", stream_if.rd_valid, obuf_m != 0);
                end
                n_checks++;
                if (m_ren !== m_exp_ren) begin
                    n_fail++; $display("FAIL mem_ren: got %b expected %b", m_ren, m_exp_ren);
                end
                if (m_push) begin
                    n_checks++;
                    if (tile_if.mem_waddr !== wa_m[9:0]) begin
                        n_fail++; $display("FAIL mem_waddr: got %0d expected %0d", tile_if.mem_waddr, wa_m[9:0]);
                    end
                end
                if (m_ren) begin
                    n_checks++;
                    if (tile_if.mem_raddr !== ra_m[9:0]) begin
                        n_fail++; $display("FAIL mem_raddr: got %0d expected %0d", tile_if.mem_raddr, ra_m[9:0]);
                    end
                end
                if (m_pop && !flush) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL rd_data: got %h expected nothing (empty)", stream_if.rd_data);
                    end else begin
                        m_exp_data = exp_q.pop_front();
                        if (stream_if.rd_data !== m_exp_data) begin
                            n_fail++; $display("FAIL rd_data: got %h expected %h", stream_if.rd_data, m_exp_data);
                        end
                    end
                    pop_total++;
                end
                if (flush) begin
                    exp_q.delete();
                    wa_m = '0; ra_m = '0; obuf_m = 0; infl_m = 0;
                end else begin
                    if (m_push) begin
                        exp_q.push_back(stream_if.wr_data);
                        wa_m = wa_m + 11'd1;
                    end
                    if (m_ren) begin
                        ra_m = ra_m + 11'd1;
                        ren_total++;
                    end
                    obuf_m = m_occ;
                    infl_m = m_ren;
                end
                alive_m = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base, output bit ok);
        int acc = 0;
        int guard = 0;
        bit a;
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'(base);
        while (acc < n && guard < 5000) begin
            @(negedge clk);
            a = stream_if.wr_ready;
            step();
            if (a) begin
                acc++;
                stream_if.wr_data = 8'(base + acc);
            end
            guard++;
        end
        stream_if.wr_valid = 1'b0;
        ok = (acc == n);
    endtask

    task automatic drain(output bit ok);
        int guard = 0;
        stream_if.wr_valid = 1'b0;
        stream_if.rd_ready = 1'b1;
        while ((count != 0 || stream_if.rd_valid) && guard < 3000) begin
            step();
            guard++;
        end
        ok = (count == 0) && !stream_if.rd_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        stream_if.wr_valid = 1'b0; stream_if.wr_data = 8'h00; stream_if.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({stream_if.wr_ready, stream_if.rd_valid, almost_full, tile_if.mem_wen, tile_if.mem_ren} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                {stream_if.wr_ready, stream_if.rd_valid, almost_full, tile_if.mem_wen, tile_if.mem_ren});
        end
        n_checks++;
        if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (tile_if.mem_waddr !== 10'd0 || tile_if.mem_raddr !== 10'd0) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", tile_if.mem_waddr, tile_if.mem_raddr);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (stream_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_wr_ready: got %b expected 0", stream_if.wr_ready); end
        step();
        n_checks++;
        if (stream_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL alive_wr_ready: got %b expected 1", stream_if.wr_ready); end
    endtask

    task automatic test_single();
        stream_if.rd_ready = 1'b1;
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'hA5;
        #1;
        n_checks++;
        if (tile_if.mem_wen !== 1'b1 || tile_if.mem_waddr !== 10'd0) begin
            n_fail++; $display("FAIL single_write: got wen=%b addr=%0d expected 1/0", tile_if.mem_wen, tile_if.mem_waddr);
        end
        step();
        stream_if.wr_valid = 1'b0;
        #1;
        n_checks++;
        if (tile_if.mem_ren !== 1'b1 || tile_if.mem_raddr !== 10'd0) begin
            n_fail++; $display("FAIL single_read: got ren=%b addr=%0d expected 1/0", tile_if.mem_ren, tile_if.mem_raddr);
        end
        step();
        n_checks++;
        if (stream_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got rd_valid=%b expected 0", stream_if.rd_valid); end
        step();
        n_checks++;
        if (stream_if.rd_valid !== 1'b1 || stream_if.rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_out: got %b/%h expected 1/a5", stream_if.rd_valid, stream_if.rd_data);
        end
        step();
        n_checks++;
        if (count !== '0 || stream_if.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_after: got count=%0d rd_valid=%b expected 0/0", count, stream_if.rd_valid);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int r0;
        r0 = ren_total;
        stream_if.rd_ready = 1'b0;
        push_n(1026, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fill_timeout: got incomplete expected 1026 pushes"); end
        step();
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'hEE;
        #1;
        n_checks++;
        if (stream_if.wr_ready !== 1'b0 || tile_if.mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL fill_blocked: got ready=%b wen=%b expected 0/0", stream_if.wr_ready, tile_if.mem_wen);
        end
        repeat (3) step();
        stream_if.wr_valid = 1'b0;
        n_checks++;
        if (count !== count_t'(1026) || almost_full !== 1'b1) begin
            n_fail++; $display("FAIL fill_count: got %0d af=%b expected 1026/1", count, almost_full);
        end
        n_checks++;
        if (stream_if.rd_valid !== 1'b1 || stream_if.rd_data !== 8'h00) begin
            n_fail++; $display("FAIL fill_head: got %b/%h expected 1/00", stream_if.rd_valid, stream_if.rd_data);
        end
        n_checks++;
        if (ren_total - r0 != 2) begin n_fail++; $display("FAIL fill_reads: got %0d expected 2", ren_total - r0); end
    endtask

    task automatic test_back_to_back();
        int pushes = 0;
        int pops = 0;
        int n = 1026;
        bit a, p, ok;
        stream_if.rd_ready = 1'b1;
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'(n);
        for (int c = 0; c < 2100; c++) begin
            @(negedge clk);
            a = stream_if.wr_ready;
            p = stream_if.rd_valid;
            n_checks++;
            if (count < count_t'(1025)) begin n_fail++; $display("FAIL b2b_level: got %0d expected >=1025", count); end
            step();
            if (a) begin pushes++; n++; stream_if.wr_data = 8'(n); end
            if (p) pops++;
        end
        stream_if.wr_valid = 1'b0;
        n_checks++;
        if (pops != 2100 || pushes != 2099) begin
            n_fail++; $display("FAIL b2b_rate: got pops=%0d pushes=%0d expected 2100/2099", pops, pushes);
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain: got count=%0d expected 0", count); end
    endtask

    task automatic test_random();
        int p0 = pop_total;
        int guard = 0;
        bit ok;
        while (pop_total - p0 < 5000 && guard < 40000) begin
            stream_if.wr_valid = ($urandom_range(0, 99) < 60);
            stream_if.wr_data  = 8'($urandom);
            stream_if.rd_ready = ($urandom_range(0, 99) < (((guard / 700) % 2) != 0 ? 75 : 40));
            step();
            guard++;
        end
        n_checks++;
        if (pop_total - p0 < 5000) begin n_fail++; $display("FAIL random_progress: got %0d pops expected 5000", pop_total - p0); end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL random_drain: got count=%0d expected 0", count); end
    endtask

    task automatic test_flush();
        bit ok;
        stream_if.rd_ready = 1'b0;
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'h77;
        step();
        stream_if.wr_data  = 8'h78;
        #1;
        n_checks++;
        if (tile_if.mem_ren !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ren: got %b expected 1", tile_if.mem_ren); end
        step();
        stream_if.wr_data = 8'h99;
        flush = 1'b1;
        #1;
        n_checks++;
        if ({tile_if.mem_wen, tile_if.mem_ren, stream_if.wr_ready} !== 3'b000) begin
            n_fail++; $display("FAIL flush_quiet: got wen/ren/ready=%b expected 000",
                {tile_if.mem_wen, tile_if.mem_ren, stream_if.wr_ready});
        end
        step();
        flush = 1'b0;
        stream_if.wr_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== '0 || stream_if.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got count=%0d rd_valid=%b expected 0/0", count, stream_if.rd_valid);
        end
        step();
        n_checks++;
        if (stream_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got rd_valid=%b expected 0", stream_if.rd_valid); end
        stream_if.rd_ready = 1'b1;
        stream_if.wr_valid = 1'b1;
        stream_if.wr_data  = 8'h3C;
        #1;
        n_checks++;
        if (tile_if.mem_wen !== 1'b1 || tile_if.mem_waddr !== 10'd0) begin
            n_fail++; $display("FAIL flush_waddr: got wen=%b addr=%0d expected 1/0", tile_if.mem_wen, tile_if.mem_waddr);
        end
        step();
        stream_if.wr_valid = 1'b0;
        #1;
        n_checks++;
        if (tile_if.mem_ren !== 1'b1 || tile_if.mem_raddr !== 10'd0) begin
            n_fail++; $display("FAIL flush_raddr: got ren=%b addr=%0d expected 1/0", tile_if.mem_ren, tile_if.mem_raddr);
        end
        step();
        step();
        n_checks++;
        if (stream_if.rd_valid !== 1'b1 || stream_if.rd_data !== 8'h3C) begin
            n_fail++; $display("FAIL flush_readback: got %b/%h expected 1/3c", stream_if.rd_valid, stream_if.rd_data);
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL flush_drain: got count=%0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        stream_if.rd_ready = 1'b0;
        push_n(500, 16, ok);
        n_checks++;
        if (!ok || count !== count_t'(500)) begin n_fail++; $display("FAIL mid_level: got %0d expected 500", count); end
        stream_if.wr_valid = 1'b1;
        stream_if.rd_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stream_if.wr_ready, stream_if.rd_valid, almost_full, tile_if.mem_wen, tile_if.mem_ren} !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset_flags: got %b expected 00000",
                {stream_if.wr_ready, stream_if.rd_valid, almost_full, tile_if.mem_wen, tile_if.mem_ren});
        end
        n_checks++;
        if (count !== '0 || tile_if.mem_waddr !== 10'd0 || tile_if.mem_raddr !== 10'd0) begin
            n_fail++; $display("FAIL mid_reset_state: got count=%0d waddr=%0d raddr=%0d expected 0/0/0",
                count, tile_if.mem_waddr, tile_if.mem_raddr);
        end
        repeat (2) step();
        stream_if.wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();
        push_n(8, 192, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_repush: got incomplete expected 8 pushes"); end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_drain: got count=%0d expected 0", count); end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
